// File: rtl/block_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : block_ram_arbiter
// Description : Round-robin arbiter that shares one single-port block RAM
//               between NUM_REQUESTERS valid/ready masters. The grant is
//               registered onto the RAM port. Read data is routed back to the
//               owning master after a fixed latency.
// Options     : define BLOCK_RAM_ARBITER_PERF_EN to add per-master grant
//               counters and a conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module block_ram_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic [NUM_REQUESTERS-1:0]            req_write,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_REQUESTERS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_data,
  output logic                                 ram_write_enabled,
  output logic [ADDR_WIDTH-1:0]                ram_address,
  output logic [DATA_WIDTH-1:0]                ram_write_data,
  input  logic [DATA_WIDTH-1:0]                ram_read_data
`ifdef BLOCK_RAM_ARBITER_PERF_EN
  ,
  output logic [NUM_REQUESTERS*32-1:0]         grant_count,
  output logic [31:0]                          conflict_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQUESTERS);

  // Arbitration state and registered RAM port
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  // Read tag sitting alongside the address on the RAM port. It enters the
  // READ_LATENCY-deep return pipeline when the RAM captures the address.
  logic                  rd_port_valid_q, rd_port_valid_d;
  logic [ID_W-1:0]       rd_port_id_q, rd_port_id_d;

  logic [READ_LATENCY-1:0]           pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;

  // Arbiter outputs
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            accept;
  int              cand;

  // Round-robin search starting just after the last granted master
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      if (!grant_found) begin
        cand = (int'(last_grant_q) + k) % NUM_REQUESTERS;
        if (req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand[ID_W-1:0];
        end
      end
    end
  end

  // One-hot ready; held low while reset is asserted so nothing is accepted
  always_comb begin
    req_ready = '0;
    if (grant_found && resetn) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // Next state for the RAM port, grant pointer and read-return pipeline
  always_comb begin
    last_grant_d    = last_grant_q;
    ram_we_d        = 1'b0;
    ram_addr_d      = ram_addr_q;
    ram_wdata_d     = ram_wdata_q;
    rd_port_valid_d = 1'b0;
    rd_port_id_d    = rd_port_id_q;
    if (accept) begin
      last_grant_d    = grant_idx;
      ram_we_d        = req_write[grant_idx];
      ram_addr_d      = req_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata_d     = req_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      rd_port_valid_d = ~req_write[grant_idx];
      rd_port_id_d    = grant_idx;
    end
    pipe_valid_d[0] = rd_port_valid_q;
    pipe_id_d[0]    = rd_port_id_q;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_id_d[s]    = pipe_id_q[s-1];
    end
  end

  // State registers; reset discards in-flight reads and cancels a pending write
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_grant_q    <= ID_W'(NUM_REQUESTERS - 1);
      ram_we_q        <= 1'b0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
      rd_port_valid_q <= 1'b0;
      rd_port_id_q    <= '0;
      pipe_valid_q    <= '0;
      pipe_id_q       <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      ram_we_q        <= ram_we_d;
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
      rd_port_valid_q <= rd_port_valid_d;
      rd_port_id_q    <= rd_port_id_d;
      pipe_valid_q    <= pipe_valid_d;
      pipe_id_q       <= pipe_id_d;
    end
  end

  assign ram_write_enabled = ram_we_q;
  assign ram_address       = ram_addr_q;
  assign ram_write_data    = ram_wdata_q;

  // Steer the response pulse to the owning master; never to an invalid index
  always_comb begin
    resp_valid = '0;
    if (pipe_valid_q[READ_LATENCY-1] &&
        (int'(pipe_id_q[READ_LATENCY-1]) < NUM_REQUESTERS)) begin
      resp_valid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign resp_data = ram_read_data;

`ifdef BLOCK_RAM_ARBITER_PERF_EN
  logic [NUM_REQUESTERS-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                     conflict_cnt_q, conflict_cnt_d;
  logic                            multi_valid;

  // Two or more valid bits: clearing the lowest set bit leaves something
  assign multi_valid = (req_valid & (req_valid - {{(NUM_REQUESTERS-1){1'b0}}, 1'b1})) != '0;

  // Counter increments; both wrap naturally at 2^32
  always_comb begin
    grant_cnt_d    = grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (accept) begin
      grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 32'd1;
    end
    if (multi_valid) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_count    = grant_cnt_q;
  assign conflict_count = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_ram_arbiter
// Description : Directed self-checking bench for block_ram_arbiter with two
//               masters and a one-cycle synchronous RAM model. Define
//               BLOCK_RAM_ARBITER_PERF_EN to also exercise the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_ram_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 1;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid, req_ready, req_write, resp_valid;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_write_data;
  logic [DW-1:0]   resp_data, ram_write_data, ram_read_data;
  logic            ram_write_enabled;
  logic [AW-1:0]   ram_address;
`ifdef BLOCK_RAM_ARBITER_PERF_EN
  logic [N*32-1:0] grant_count;
  logic [31:0]     conflict_count;
`endif

  block_ram_arbiter #(
    .NUM_REQUESTERS(N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .READ_LATENCY  (RL)
  ) u_dut (
    .clock            (clock),
    .resetn           (resetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_write_data   (req_write_data),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .ram_write_enabled(ram_write_enabled),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
`ifdef BLOCK_RAM_ARBITER_PERF_EN
    ,
    .grant_count      (grant_count),
    .conflict_count   (conflict_count)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-first, one edge of read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_write_enabled) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  // Cycle counter, bumped at every active edge
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Response log sampled on the falling edge
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            cyc;
  } resp_t;
  resp_t resp_q[$];

  always @(negedge clock) begin
    if (resp_valid != '0) begin
      resp_t r;
      r.id   = (resp_valid == 2'b01) ? 0 : (resp_valid == 2'b10) ? 1 : -1;
      r.data = resp_data;
      r.cyc  = cyc;
      resp_q.push_back(r);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int m, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[m]               = v;
    req_write[m]               = w;
    req_address[m*AW +: AW]    = a;
    req_write_data[m*DW +: DW] = d;
  endtask

  // Contention stimulus: M0 gets a fourth write so it stays busy after M1 finishes
  logic [AW-1:0] m0_a [5] = '{16'hf0, 16'hf1, 16'hf2, 16'hf0, 16'h0};
  logic [DW-1:0] m0_d [5] = '{32'hff00, 32'hff11, 32'hff22, 32'hff00, 32'h0};
  logic [AW-1:0] m1_a [3] = '{16'hf3, 16'hf4, 16'h0};
  logic [DW-1:0] m1_d [3] = '{32'hff33, 32'hff44, 32'h0};
  logic [N-1:0]  exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
  logic [DW-1:0] exp_rd [5] = '{32'hff00, 32'hff11, 32'hff22, 32'hff33, 32'hff44};

  initial begin
    int           acc;
    int           p0;
    int           p1;
    logic [N-1:0] g;

    resetn         = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;

    // ---- reset: nothing accepted while held low ----
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ready", req_ready, 0);
      check("rst_we", ram_write_enabled, 0);
    end
    check("rst_addr", ram_address, 0);
    check("rst_wdata", ram_write_data, 0);
    check("rst_resp", resp_valid, 0);
    resetn = 1'b1;
    #1;
    check("first_grant", req_ready, 2'b01);
    req_valid = '0;
    step();

    // ---- single master write then read ----
    resp_q.delete();
    drive(0, 1'b1, 1'b1, 16'hf0, 32'h11223344);
    #1;
    check("sm_wr_ready", req_ready, 2'b01);
    step();
    check("sm_we", ram_write_enabled, 1);
    check("sm_addr", ram_address, 16'hf0);
    check("sm_wdata", ram_write_data, 32'h11223344);
    drive(0, 1'b1, 1'b0, 16'hf0, 32'h0);
    #1;
    check("sm_rd_ready", req_ready, 2'b01);
    step();
    acc = cyc;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("sm_we_one_cycle", ram_write_enabled, 0);
    repeat (4) step();
    check("sm_resp_count", resp_q.size(), 1);
    if (resp_q.size() > 0) begin
      check("sm_resp_id", resp_q[0].id, 0);
      check("sm_resp_data", resp_q[0].data, 32'h11223344);
      check("sm_resp_lat", resp_q[0].cyc - acc, RL);
    end

    // ---- contention: grants alternate, then M0 alone ----
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, p0 < 4, 1'b1, m0_a[p0], m0_d[p0]);
      drive(1, p1 < 2, 1'b1, m1_a[p1], m1_d[p1]);
      #1;
      g = req_ready;
      check($sformatf("ct_grant%0d", c), g, exp_g[c]);
      step();
      if (g[0]) p0++;
      if (g[1]) p1++;
    end
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    resp_q.delete();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, AW'(16'hf0 + k), 32'h0);
      step();
    end
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (4) step();
    check("ct_rd_count", resp_q.size(), 5);
    for (int k = 0; k < 5 && k < resp_q.size(); k++) begin
      check($sformatf("ct_rd_data%0d", k), resp_q[k].data, exp_rd[k]);
      check($sformatf("ct_rd_id%0d", k), resp_q[k].id, 0);
    end

    // ---- cross-master read-after-write ----
    resp_q.delete();
    drive(0, 1'b1, 1'b1, 16'h10, 32'hdeadbeef);
    step();
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h10, 32'h0);
    #1;
    check("raw_ready", req_ready, 2'b10);
    step();
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (4) step();
    check("raw_count", resp_q.size(), 1);
    if (resp_q.size() > 0) begin
      check("raw_id", resp_q[0].id, 1);
      check("raw_data", resp_q[0].data, 32'hdeadbeef);
    end

    // ---- reset mid-flight: read dropped, pending write cancelled ----
    resp_q.delete();
    drive(1, 1'b1, 1'b0, 16'hf3, 32'h0);
    #1;
    check("mf_ready", req_ready, 2'b10);
    step();
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(0, 1'b1, 1'b1, 16'hf5, 32'hcafe);
    resetn = 1'b0;
    #1;
    check("mf_ready_rst", req_ready, 0);
    step();
    check("mf_we", ram_write_enabled, 0);
    check("mf_addr", ram_address, 0);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    resetn = 1'b1;
    repeat (4) step();
    check("mf_no_resp", resp_q.size(), 0);

`ifdef BLOCK_RAM_ARBITER_PERF_EN
    // ---- performance counters ----
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("pc_g0_rst", grant_count[31:0], 0);
    check("pc_g1_rst", grant_count[63:32], 0);
    check("pc_cf_rst", conflict_count, 0);
    drive(0, 1'b1, 1'b0, 16'h1, 32'h0);
    drive(1, 1'b1, 1'b0, 16'h2, 32'h0);
    repeat (10) step();
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    step();
    check("pc_g0", grant_count[31:0], 5);
    check("pc_g1", grant_count[63:32], 5);
    check("pc_cf", conflict_count, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
